// File: rtl/memory_stage_pkg.sv
// Shared pipeline definitions for the memory stage.
// Contents:
//   mem_state_e         - FSM states (IDLE, BUSY).
//   wb_bundle_t         - write-back register bundle {regdest, writereg, wbvalue}.
//   WB_BUBBLE           - write-back bundle carrying no instruction.
//   MEM_TIMEOUT_DEFAULT - default number of BUSY cycles before an access is abandoned.
package memory_stage_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } mem_state_e;

    typedef struct packed {
        logic [4:0]  regdest;
        logic        writereg;
        logic [31:0] wbvalue;
    } wb_bundle_t;

    localparam wb_bundle_t WB_BUBBLE = '{regdest: 5'd0, writereg: 1'b0, wbvalue: 32'd0};

    localparam int unsigned MEM_TIMEOUT_DEFAULT = 32'd255;

endpackage

// File: rtl/memory_stage_timeout.sv
// Saturating BUSY-cycle counter for the memory stage.
// Ports:
//   clk, rst_n - clock and asynchronous active-low reset.
//   clear      - synchronous clear to zero (takes priority over enable).
//   enable     - count up by one; holds at all-ones instead of wrapping.
//   tc         - terminal count: high while the count equals TIMEOUT-1.
module mem_timeout_counter
    import memory_stage_pkg::*;
#(
    parameter int unsigned TIMEOUT = MEM_TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic tc
);

    localparam int unsigned   CW      = $clog2(TIMEOUT + 32'd1);
    localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};
    localparam logic [CW-1:0] TC_VAL  = CW'(TIMEOUT - 32'd1);

    logic [CW-1:0] cnt_r;

    // Counter register: clear wins, otherwise count up and stick at the top value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= {CW{1'b0}};
        end else if (clear) begin
            cnt_r <= {CW{1'b0}};
        end else if (enable && (cnt_r != CNT_MAX)) begin
            cnt_r <= cnt_r + CW'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign tc = (cnt_r == TC_VAL);

endmodule

// File: rtl/memory_stage.sv
// Memory stage of the five-stage pipeline.
// Takes the registered Execute outputs, performs loads/stores on an external
// data-memory port using a req/ack handshake, stalls upstream while an access
// is outstanding and registers the write-back bundle for the Writeback stage.
// Ports:
//   clk, rst_n        - clock, asynchronous active-low reset.
//   id_mem_*          - instruction fields from Execute (held while mem_stall).
//   mem_stall         - combinational hold request to Fetch/Decode/Execute.
//   mem_req/we/addr/wdata - registered data-memory request.
//   mem_rdata, mem_ack    - data-memory response (ack is a one-cycle pulse).
//   mem_wb_*          - registered write-back bundle (writereg=0 is a bubble).
//   mem_err           - sticky error (misaligned access or timeout).
module memory_stage
    import memory_stage_pkg::*;
#(
    parameter int unsigned TIMEOUT = MEM_TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        id_mem_readmem,
    input  logic        id_mem_writemem,
    input  logic [31:0] id_mem_regb,
    input  logic        id_mem_selwsource,
    input  logic [4:0]  id_mem_regdest,
    input  logic        id_mem_writereg,
    input  logic [31:0] id_mem_wbvalue,
    output logic        mem_stall,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic [4:0]  mem_wb_regdest,
    output logic        mem_wb_writereg,
    output logic [31:0] mem_wb_wbvalue,
    output logic        mem_err
);

    mem_state_e  state_r;
    logic        mem_req_r;
    logic        mem_we_r;
    logic [31:0] mem_addr_r;
    logic [31:0] mem_wdata_r;
    wb_bundle_t  wb_r;
    logic        err_r;

    logic        access_s;
    logic        misaligned_s;
    logic        ack_s;
    logic        tc_s;
    logic        cnt_clear_s;
    logic        cnt_en_s;
    logic        stall_s;
    wb_bundle_t  wb_pass_s;
    wb_bundle_t  wb_done_s;

    assign access_s     = id_mem_readmem | id_mem_writemem;
    assign misaligned_s = access_s & (id_mem_wbvalue[1:0] != 2'b00);
    // A stray ack with no request outstanding (e.g. after reset) is ignored.
    assign ack_s        = mem_ack & mem_req_r;
    assign cnt_clear_s  = (state_r == ST_IDLE);
    assign cnt_en_s     = (state_r == ST_BUSY) & ~ack_s;

    mem_timeout_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (cnt_clear_s),
        .enable (cnt_en_s),
        .tc     (tc_s)
    );

    // Upstream hold: the issuing IDLE cycle and every BUSY cycle that neither acks nor times out.
    always_comb begin
        stall_s = 1'b0;
        if (state_r == ST_BUSY) begin
            stall_s = ~ack_s & ~tc_s;
        end else begin
            stall_s = access_s & ~misaligned_s;
        end
    end

    // Write-back candidates: plain pass-through, and completion of an acked access.
    always_comb begin
        wb_pass_s = '{regdest: id_mem_regdest, writereg: id_mem_writereg, wbvalue: id_mem_wbvalue};
        wb_done_s = WB_BUBBLE;
        wb_done_s.regdest  = id_mem_regdest;
        // Stores never write the register file.
        wb_done_s.writereg = id_mem_writereg & ~id_mem_writemem;
        if (id_mem_selwsource) begin
            wb_done_s.wbvalue = mem_rdata;
        end else begin
            wb_done_s.wbvalue = id_mem_wbvalue;
        end
    end

    // Access FSM together with the request, write-back and error registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            mem_req_r   <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= 32'd0;
            mem_wdata_r <= 32'd0;
            wb_r        <= WB_BUBBLE;
            err_r       <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (!access_s) begin
                        wb_r <= wb_pass_s;
                    end else if (misaligned_s) begin
                        wb_r  <= WB_BUBBLE;
                        err_r <= 1'b1;
                    end else begin
                        mem_req_r   <= 1'b1;
                        mem_we_r    <= id_mem_writemem;
                        mem_addr_r  <= id_mem_wbvalue;
                        mem_wdata_r <= id_mem_regb;
                        wb_r        <= WB_BUBBLE;
                        state_r     <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    // Ack is checked first so it beats a coincident timeout.
                    if (ack_s) begin
                        mem_req_r <= 1'b0;
                        wb_r      <= wb_done_s;
                        state_r   <= ST_IDLE;
                    end else if (tc_s) begin
                        mem_req_r <= 1'b0;
                        err_r     <= 1'b1;
                        wb_r      <= WB_BUBBLE;
                        state_r   <= ST_IDLE;
                    end else begin
                        wb_r <= WB_BUBBLE;
                    end
                end
                default: begin
                    mem_req_r <= 1'b0;
                    wb_r      <= WB_BUBBLE;
                    state_r   <= ST_IDLE;
                end
            endcase
        end
    end

    assign mem_stall       = stall_s;
    assign mem_req         = mem_req_r;
    assign mem_we          = mem_we_r;
    assign mem_addr        = mem_addr_r;
    assign mem_wdata       = mem_wdata_r;
    assign mem_wb_regdest  = wb_r.regdest;
    assign mem_wb_writereg = wb_r.writereg;
    assign mem_wb_wbvalue  = wb_r.wbvalue;
    assign mem_err         = err_r;

endmodule
